tlb_refill_walker: RTL
======================

Name: tlb_refill_walker

Overview:
- Hardware page-table walker that services misses from tlb_8_entry.
- Takes a missed VPN and fetches a two-level page table from memory (directory entry, then PTE).
- Drives the TLB random-write port with the 24-bit PTE, or raises a fault when no valid translation exists.
- Sits between the TLB/CP0 logic and the data-memory port; it is the writer side of the TLB fill interface.

Parameters:
- TIMEOUT, 255: maximum cycles a single memory request waits for mem_ack before the walk faults. Counter width is 8 bits; legal range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- miss_req  in  1  level; TLB lookup missed and a refill is wanted.
- miss_vpn  in  20  VPN that missed; sampled when the walk starts.
- ptbase  in  32  page-directory physical base; only bits [31:12] are used.
- sw_tlbw  in  1  software tlbwi/tlbwr active this cycle (shared TLB write port).
- mem_req  out  1  memory read request.
- mem_addr  out  32  word address of the read.
- mem_ack  in  1  read data valid.
- mem_rdata  in  32  read data.
- pte_out  out  24  PTE to the TLB pte_in.
- tlbwr  out  1  one-cycle TLB random-write strobe.
- busy  out  1  walk in progress.
- done  out  1  one-cycle pulse, fill completed.
- fault  out  1  one-cycle pulse, walk failed.
- fault_cause  out  2  01 = directory invalid, 10 = PTE invalid, 11 = timeout; valid with fault.

Behaviour:
- Reset (clrn=0, async): state IDLE; mem_req, tlbwr, busy, done, fault = 0; mem_addr, pte_out, fault_cause = 0; internal VPN, directory entry and timeout counter cleared.
- Entries: directory entry valid when bit 0 = 1, PT frame = bits [31:12]. PTE is mem_rdata[23:0], valid when bit 23 = 1.
- States: IDLE, DIR, PTE, FILL.
- IDLE: when miss_req=1, latch miss_vpn, go to DIR, busy=1 from the next cycle.
- DIR: mem_req=1, mem_addr = {ptbase[31:12], vpn[19:10], 2'b00}; both held stable until mem_ack.
  - On mem_ack with bit 0 = 1: latch entry, go to PTE.
  - On mem_ack with bit 0 = 0: fault with cause 01, go to IDLE.
- PTE: mem_req=1, mem_addr = {dir[31:12], vpn[9:0], 2'b00}.
  - On mem_ack with bit 23 = 1: latch pte_out, go to FILL.
  - On mem_ack with bit 23 = 0: fault with cause 10, go to IDLE.
- FILL: if sw_tlbw=0, assert tlbwr and done for one cycle, then IDLE. If sw_tlbw=1, wait; software always wins the write port.
- Timing:
  - mem_req drops in the cycle after mem_ack is sampled.
  - mem_ack is ignored while mem_req=0.
  - Zero-wait memory gives IDLE-to-tlbwr of 4 cycles (DIR 1, PTE 1, FILL 1, plus the start cycle).
- Timeout: the counter resets on entering DIR or PTE and increments each cycle without ack. When it reaches TIMEOUT: fault with cause 11, mem_req drops, go to IDLE.
- busy is high in DIR, PTE and FILL, and low in the cycle of the done/fault pulse.
- miss_req while busy is ignored. A new walk may start no earlier than the cycle after done/fault.
- miss_vpn and ptbase changes during a walk have no effect; the VPN is latched and ptbase is used only at DIR entry, where its address is registered.
- Reset mid-walk: immediate return to IDLE, mem_req=0, no tlbwr; any pending memory response is discarded.

Optional Feature:
- Macro TLB_WALKER_DIR_CACHE_EN.
- Defined:
  - Adds a one-entry directory cache (tag = vpn[19:10] and ptbase[31:12], entry, valid bit).
  - When a walk starts and the tag matches with valid=1, DIR is skipped: go straight to PTE using the cached entry.
  - The cache fills on every valid directory fetch. It is invalidated on reset and whenever ptbase changes value.
  - Zero-wait hit latency drops to 3 cycles.
- Not defined: every walk performs the DIR fetch; no extra storage.

Test Plan:
- Basic fill: ptbase=0x0001_0000, miss_vpn=0x12345, zero-wait memory. Dir read at 0x0001_0120 returns 0x0002_0001. PTE read at 0x0002_0D14 returns 0x00_8ABCDE. Required: tlbwr=1 with pte_out=0x8ABCDE exactly 4 cycles after start; done pulse.
- Invalid directory: dir returns 0x0002_0000 -> fault with cause 01, no PTE read, tlbwr never asserted.
- Invalid PTE: PTE returns 0x0000_1234 (bit 23 = 0) -> fault with cause 10, tlbwr stays 0.
- Timeout: TIMEOUT=8, mem_ack held 0 in DIR -> mem_req high for exactly 8 cycles, then fault with cause 11, busy=0.
- Port conflict: sw_tlbw=1 for 3 cycles on entry to FILL -> tlbwr asserts on the first cycle with sw_tlbw=0, pte_out unchanged. Reset mid-walk: clrn=0 in PTE with mem_req=1 -> mem_req=0 immediately, no done/fault.
- Dir cache (macro defined): two walks with VPN 0x12345 then 0x12346 -> the second issues only a PTE read, at 0x0002_0D18. A ptbase change before a third walk forces a DIR fetch.

Source files
------------

// File: rtl/tlb_refill_walker_if.sv
// Memory read port of the TLB refill walker.
// The walker is the master: it raises mem_req with a word address and holds both until
// mem_ack; the slave returns mem_rdata together with mem_ack.
//   mem_req   - read request (master -> slave)
//   mem_addr  - word address of the read (master -> slave)
//   mem_ack   - read data valid (slave -> master)
//   mem_rdata - read data (slave -> master)
interface tlb_refill_walker_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/tlb_refill_walker.sv
// Two-level hardware page-table walker for tlb_8_entry misses.
// A missed VPN selects a directory entry at {ptbase[31:12], vpn[19:10], 00}; a valid entry
// (bit 0) gives the PT frame, and the PTE at {frame, vpn[9:0], 00} (valid when bit 23) is
// written to the TLB through the random-write strobe. Invalid entries or a memory timeout
// end the walk with a fault pulse and cause code.
// Ports:
//   clk, clrn         - clock (rising edge), asynchronous active-low reset
//   miss_req/miss_vpn - refill request and the VPN that missed
//   ptbase            - page-directory physical base (bits [31:12] used)
//   sw_tlbw           - software TLB write in progress; it always wins the write port
//   mem               - memory read port (tlb_refill_walker_if.master)
//   pte_out/tlbwr     - PTE and one-cycle write strobe to the TLB
//   busy/done/fault   - walk in progress, fill-complete pulse, fault pulse
//   fault_cause       - 01 directory invalid, 10 PTE invalid, 11 timeout (valid with fault)
// Optional feature: define TLB_WALKER_DIR_CACHE_EN for a one-entry directory cache that
// skips the directory fetch when the VPN directory index and ptbase match the last fetch.
module tlb_refill_walker #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       clrn,
    input  logic                       miss_req,
    input  logic [19:0]                miss_vpn,
    input  logic [31:0]                ptbase,
    input  logic                       sw_tlbw,
    tlb_refill_walker_if.master        mem,
    output logic [23:0]                pte_out,
    output logic                       tlbwr,
    output logic                       busy,
    output logic                       done,
    output logic                       fault,
    output logic [1:0]                 fault_cause
);
    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StDir, StPte, StFill} state_e;
    state_e state_q, state_d;

    logic [19:0] vpn_q;
    logic [19:0] pt_q;      // directory base frame captured at walk start
    logic [19:0] dir_q;     // PT frame from the directory entry
    logic [7:0]  cnt_q;
    logic [23:0] pte_q;
    logic        done_q, tlbwr_q, fault_q;
    logic [1:0]  cause_q;
    logic        done_d, fault_d;
    logic [1:0]  cause_d;

    logic        in_fetch, ack, start, expired, hit;
    logic [7:0]  cnt_inc;
    logic [19:0] hit_frame;
    logic        unused_ptbase_lo;

    assign unused_ptbase_lo = ^ptbase[11:0];

    assign in_fetch = (state_q == StDir) || (state_q == StPte);
    assign ack      = in_fetch && mem.mem_ack;
    assign cnt_inc  = cnt_q + 8'd1;
    assign expired  = (cnt_inc == TimeoutCnt);
    // No new walk in the cycle that carries the previous done/fault pulse.
    assign start    = (state_q == StIdle) && miss_req && !done_q && !fault_q;

`ifdef TLB_WALKER_DIR_CACHE_EN
    logic        cache_valid_q;
    logic [9:0]  cache_vtag_q;
    logic [19:0] cache_ptag_q, cache_frame_q, ptbase_prev_q;

    assign hit       = cache_valid_q && (cache_vtag_q == miss_vpn[19:10]) &&
                       (cache_ptag_q == ptbase[31:12]);
    assign hit_frame = cache_frame_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cache_valid_q <= 1'b0;
            cache_vtag_q  <= '0;
            cache_ptag_q  <= '0;
            cache_frame_q <= '0;
            ptbase_prev_q <= '0;
        end else begin
            ptbase_prev_q <= ptbase[31:12];
            if (ptbase[31:12] != ptbase_prev_q) begin
                cache_valid_q <= 1'b0;
            end else if (state_q == StDir && ack && mem.mem_rdata[0]) begin
                cache_valid_q <= 1'b1;
                cache_vtag_q  <= vpn_q[19:10];
                cache_ptag_q  <= pt_q;
                cache_frame_q <= mem.mem_rdata[31:12];
            end
        end
    end
`else
    assign hit       = 1'b0;
    assign hit_frame = '0;
`endif

    // State register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = hit ? StPte : StDir;
            StDir: begin
                if (ack)          state_d = mem.mem_rdata[0] ? StPte : StIdle;
                else if (expired) state_d = StIdle;
            end
            StPte: begin
                if (ack)          state_d = mem.mem_rdata[23] ? StFill : StIdle;
                else if (expired) state_d = StIdle;
            end
            StFill: if (!sw_tlbw) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs and next values of the registered pulses
    always_comb begin
        mem.mem_req  = in_fetch;
        mem.mem_addr = (state_q == StPte) ? {dir_q, vpn_q[9:0], 2'b00}
                                          : {pt_q, vpn_q[19:10], 2'b00};
        busy    = (state_q != StIdle);
        done_d  = 1'b0;
        fault_d = 1'b0;
        cause_d = cause_q;
        unique case (state_q)
            StDir: begin
                if (ack && !mem.mem_rdata[0]) begin
                    fault_d = 1'b1;
                    cause_d = 2'b01;
                end else if (!ack && expired) begin
                    fault_d = 1'b1;
                    cause_d = 2'b11;
                end
            end
            StPte: begin
                if (ack && !mem.mem_rdata[23]) begin
                    fault_d = 1'b1;
                    cause_d = 2'b10;
                end else if (!ack && expired) begin
                    fault_d = 1'b1;
                    cause_d = 2'b11;
                end
            end
            StFill: done_d = !sw_tlbw;
            default: ;
        endcase
    end

    // Walk datapath and registered pulses
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            vpn_q   <= '0;
            pt_q    <= '0;
            dir_q   <= '0;
            cnt_q   <= '0;
            pte_q   <= '0;
            done_q  <= 1'b0;
            tlbwr_q <= 1'b0;
            fault_q <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            done_q  <= done_d;
            tlbwr_q <= done_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            if (start) begin
                vpn_q <= miss_vpn;
                pt_q  <= ptbase[31:12];
                cnt_q <= '0;
                if (hit) dir_q <= hit_frame;
            end else if (state_q == StDir && ack && mem.mem_rdata[0]) begin
                dir_q <= mem.mem_rdata[31:12];
                cnt_q <= '0;
            end else if (state_q == StPte && ack && mem.mem_rdata[23]) begin
                pte_q <= mem.mem_rdata[23:0];
            end else if (in_fetch && !ack) begin
                cnt_q <= cnt_inc;
            end
        end
    end

    assign pte_out     = pte_q;
    assign tlbwr       = tlbwr_q;
    assign done        = done_q;
    assign fault       = fault_q;
    assign fault_cause = cause_q;
endmodule
